// File: rtl/rr_mux_n_way.sv
// N-way, W-bit handshaked channel multiplexer with a round-robin or fixed-select grant
// and a single registered output stage. It gives full throughput when the consumer is always ready.
module rr_mux_n_way #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8,
  parameter int SEL_W = $clog2(WAYS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [WAYS*WIDTH-1:0]   in_data,
  input  logic [WAYS-1:0]         in_valid,
  output logic [WAYS-1:0]         in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_chan
);

  localparam logic [SEL_W:0] WaysExt = (SEL_W+1)'(WAYS);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;

  logic             load_en;
  logic             gnt_any;
  logic [SEL_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             xfer;

  assign load_en = !valid_q || out_ready;
  assign xfer    = reset_n && load_en && gnt_any;

  // The round-robin scan runs from the highest offset down, so the last hit wins.
  // That hit is the first valid channel at or after ptr.
  always_comb begin : grant_select
    logic [SEL_W:0] idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    if (mode) begin
      for (int i = 0; i < WAYS; i++) begin
        if (sel == SEL_W'(i) && in_valid[i]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int k = WAYS - 1; k >= 0; k--) begin
        idx = {1'b0, ptr_q} + (SEL_W+1)'(k);
        if (idx >= WaysExt) idx = idx - WaysExt;
        if (in_valid[idx[SEL_W-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = idx[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin : data_select
    gnt_data = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin : ready_decode
    in_ready = '0;
    for (int i = 0; i < WAYS; i++) begin
      in_ready[i] = xfer && (gnt_idx == SEL_W'(i));
    end
  end

  // A reload takes priority over a drain, so a simultaneous drain and load leaves no bubble.
  always_comb begin : next_state
    valid_d = valid_q;
    data_d  = data_q;
    chan_d  = chan_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      valid_d = 1'b1;
      data_d  = gnt_data;
      chan_d  = gnt_idx;
      if (!mode) ptr_d = (gnt_idx == SEL_W'(WAYS - 1)) ? '0 : gnt_idx + SEL_W'(1);
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_chan  = chan_q;

endmodule

// File: tb/tb_rr_mux_n_way.sv
// Bench for rr_mux_n_way: it drives an 8x16 instance and a 5x8 instance side by side.
// Both instances are checked every cycle against a grant/queue reference model.
module tb_rr_mux_n_way;

  localparam int WA = 8;
  localparam int DA = 16;
  localparam int WB = 5;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [WA*DA-1:0] aInData = '0;
  logic [WA-1:0]    aInValid = '0, aInReady;
  logic             aMode = 1'b0, aOutReady = 1'b0, aOutValid;
  logic [2:0]       aSel = '0, aOutChan;
  logic [DA-1:0]    aOutData;

  logic [WB*DB-1:0] bInData = '0;
  logic [WB-1:0]    bInValid = '0, bInReady;
  logic             bMode = 1'b0, bOutReady = 1'b0, bOutValid;
  logic [2:0]       bSel = '0, bOutChan;
  logic [DB-1:0]    bOutData;

  rr_mux_n_way #(.WIDTH(DA), .WAYS(WA)) dutA (
    .clk(clk), .reset_n(reset_n), .in_data(aInData), .in_valid(aInValid),
    .in_ready(aInReady), .mode(aMode), .sel(aSel), .out_data(aOutData),
    .out_valid(aOutValid), .out_ready(aOutReady), .out_chan(aOutChan)
  );

  rr_mux_n_way #(.WIDTH(DB), .WAYS(WB)) dutB (
    .clk(clk), .reset_n(reset_n), .in_data(bInData), .in_valid(bInValid),
    .in_ready(bInReady), .mode(bMode), .sel(bSel), .out_data(bOutData),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_chan(bOutChan)
  );

  int assertCount = 0;
  int failCount = 0;

  int          mPtr[2];
  bit          mVal[2];
  logic [15:0] mData[2];
  int          mChan[2];
  logic [7:0]  accA = '0, accB = '0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int refGrant(input int ways, input logic [7:0] valid, input logic mode,
                                  input int sel, input int ptr);
    if (mode) return (sel < ways && valid[sel]) ? sel : -1;
    for (int k = 0; k < ways; k++) begin
      if (valid[(ptr + k) % ways]) return (ptr + k) % ways;
    end
    return -1;
  endfunction

  task automatic resetModel();
    for (int j = 0; j < 2; j++) begin
      mPtr[j] = 0; mVal[j] = 1'b0; mData[j] = '0; mChan[j] = 0;
    end
    accA = '0;
    accB = '0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model across the edge.
  task automatic runCycle(input string tag);
    int gA, gB;
    bit ldA, ldB;
    logic [7:0] expA, expB;
    #2;
    ldA  = !mVal[0] || aOutReady;
    ldB  = !mVal[1] || bOutReady;
    gA   = refGrant(WA, aInValid, aMode, int'(aSel), mPtr[0]);
    gB   = refGrant(WB, 8'(bInValid), bMode, int'(bSel), mPtr[1]);
    expA = (ldA && gA >= 0) ? 8'(1 << gA) : 8'h00;
    expB = (ldB && gB >= 0) ? 8'(1 << gB) : 8'h00;
    checkOutput({tag, "/aRdy"},  32'(aInReady),  32'(expA));
    checkOutput({tag, "/aVal"},  32'(aOutValid), 32'(mVal[0]));
    checkOutput({tag, "/aData"}, 32'(aOutData),  32'(mData[0]));
    checkOutput({tag, "/aChan"}, 32'(aOutChan),  32'(mChan[0]));
    checkOutput({tag, "/bRdy"},  32'(bInReady),  32'(expB));
    checkOutput({tag, "/bVal"},  32'(bOutValid), 32'(mVal[1]));
    checkOutput({tag, "/bData"}, 32'(bOutData),  32'(mData[1][7:0]));
    checkOutput({tag, "/bChan"}, 32'(bOutChan),  32'(mChan[1]));
    @(posedge clk);
    if (ldA && gA >= 0) begin
      mVal[0] = 1'b1; mData[0] = aInData[gA*DA +: DA]; mChan[0] = gA;
      if (!aMode) mPtr[0] = (gA + 1) % WA;
    end else if (mVal[0] && aOutReady) mVal[0] = 1'b0;
    if (ldB && gB >= 0) begin
      mVal[1] = 1'b1; mData[1] = 16'(bInData[gB*DB +: DB]); mChan[1] = gB;
      if (!bMode) mPtr[1] = (gB + 1) % WB;
    end else if (mVal[1] && bOutReady) mVal[1] = 1'b0;
    accA = expA;
    accB = expB;
    #1;
  endtask

  task automatic asyncReset();
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst/aVal",  32'(aOutValid), 32'd0);
    checkOutput("rst/aData", 32'(aOutData),  32'd0);
    checkOutput("rst/aChan", 32'(aOutChan),  32'd0);
    checkOutput("rst/aRdy",  32'(aInReady),  32'd0);
    checkOutput("rst/bVal",  32'(bOutValid), 32'd0);
    checkOutput("rst/bRdy",  32'(bInReady),  32'd0);
    resetModel();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Producers hold a word until it is accepted, then offer a fresh word or go idle.
  task automatic applyStimulus();
    for (int i = 0; i < WA; i++) begin
      if (!aInValid[i] || accA[i]) begin
        aInValid[i] = ($urandom_range(0, 3) != 0);
        aInData[i*DA +: DA] = 16'($urandom);
      end
    end
    for (int i = 0; i < WB; i++) begin
      if (!bInValid[i] || accB[i]) begin
        bInValid[i] = ($urandom_range(0, 3) != 0);
        bInData[i*DB +: DB] = 8'($urandom);
      end
    end
    aOutReady = ($urandom_range(0, 3) != 0);
    bOutReady = ($urandom_range(0, 3) != 0);
    aMode = ($urandom_range(0, 3) == 0);
    bMode = ($urandom_range(0, 3) == 0);
    aSel  = 3'($urandom_range(0, 7));
    bSel  = 3'($urandom_range(0, 7));
  endtask

  initial begin
    resetModel();
    aInValid = '1;
    @(posedge clk);
    #1;
    asyncReset();

    for (int i = 0; i < WA; i++) aInData[i*DA +: DA] = 16'h1000 + 16'(i);
    for (int i = 0; i < WB; i++) bInData[i*DB +: DB] = 8'h40 + 8'(i);
    aInValid = '1; bInValid = '1; aOutReady = 1'b1; bOutReady = 1'b1;
    for (int i = 0; i < 9; i++) begin
      runCycle("allValid");
      checkOutput("seq/aChan", 32'(aOutChan), 32'(i % WA));
      checkOutput("seq/aData", 32'(aOutData), 32'h1000 + 32'(i % WA));
      checkOutput("seq/bChan", 32'(bOutChan), 32'(i % WB));
    end

    aInValid = 8'b0010_0100;
    bMode = 1'b1; bSel = 3'd7;
    for (int i = 0; i < 4; i++) begin
      runCycle("twoChan");
      checkOutput("alt/aChan", 32'(aOutChan), (i % 2 == 0) ? 32'd2 : 32'd5);
    end
    checkOutput("noGrant/bVal", 32'(bOutValid), 32'd0);

    aInValid = 8'b0000_1000;
    aInData[3*DA +: DA] = 16'hBEEF;
    bMode = 1'b0;
    runCycle("bpLoad");
    aOutReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      runCycle("bpHold");
      checkOutput("hold/aData", 32'(aOutData), 32'hBEEF);
      checkOutput("hold/aRdy",  32'(aInReady), 32'd0);
    end
    aOutReady = 1'b1;
    runCycle("bpRelease");

    for (int i = 0; i < WA; i++) aInData[i*DA +: DA] = 16'h2000 + 16'(i);
    aInValid = '1; aMode = 1'b1; aSel = 3'd6;
    for (int i = 0; i < 4; i++) begin
      runCycle("fixedSel");
      checkOutput("fixed/aChan", 32'(aOutChan), 32'd6);
    end
    aMode = 1'b0;
    runCycle("resume");
    checkOutput("resume/aChan", 32'(aOutChan), 32'd4);
    runCycle("resume");
    runCycle("resume");

    asyncReset();
    runCycle("postReset");
    checkOutput("postRst/aChan", 32'(aOutChan), 32'd0);

    for (int n = 0; n < 400; n++) begin
      applyStimulus();
      runCycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/rr_mux_n_way.md
Name: rr_mux_n_way

Overview:
- Parametrised N-way, W-bit channel multiplexer with a per-channel valid/ready handshake and one registered output stage.
- Two modes:
  - round-robin arbitration across all requesting channels;
  - fixed select, which behaves like a plain select-driven mux but is handshaked.
- Sits between multiple producers (e.g. register-file read ports, I/O sources) and one consumer bus in the CPU/memory datapath.

Parameters:
- WIDTH, 16, data width per channel in bits (>=1).
- WAYS, 8, number of input channels (>=2; need not be a power of two).
- SEL_W, $clog2(WAYS), width of sel/out_chan. Derived; never overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  WAYS*WIDTH  channel i occupies bits [WIDTH*i +: WIDTH].
- in_valid  input  WAYS  channel i has a word offered.
- in_ready  output  WAYS  channel i word is accepted this cycle.
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SEL_W  channel index used when mode=1.
- out_data  output  WIDTH  registered output word.
- out_valid  output  1  out_data/out_chan hold a word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_chan  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_chan=0, rr pointer ptr=0. in_ready=0 while reset_n=0.
- load_en = !out_valid | out_ready (combinational). This gives full throughput: one word per cycle when the consumer is always ready.
- Grant, combinational, one-hot or zero:
  - Mode 0: the first i with in_valid[i]=1, scanning ptr, ptr+1, ..., WAYS-1, 0, ..., ptr-1 (wrap modulo WAYS).
  - Mode 1: grant[sel]=in_valid[sel]. If sel>=WAYS, no grant.
- in_ready[i] = load_en & grant[i]. At most one bit is set. in_ready is asserted independent of the channel's own valid only via grant, so in_ready[i]=1 implies in_valid[i]=1.
- Transfer-in occurs when any in_ready bit is 1. On the next edge: out_data <= granted word, out_chan <= granted index, out_valid <= 1.
- Latency: 1 cycle from input transfer to out_valid.
- Drain: out_valid & out_ready with no transfer-in sets out_valid <= 0. out_data and out_chan hold their last values.
- Hold: out_valid & !out_ready keeps out_data, out_chan and out_valid stable. in_ready stays all-zero.
- Simultaneous drain and transfer-in: the register is reloaded and out_valid stays 1, with no bubble.
- Pointer: on a mode-0 transfer-in, ptr <= (granted+1) mod WAYS; when granted=WAYS-1, ptr wraps to 0. Mode-1 transfers and idle cycles leave ptr unchanged.
- Fairness: with all channels continuously valid in mode 0, each channel gets exactly one grant per WAYS transfers.
- Mode/sel changes take effect on the same cycle's grant. A word already in the output register is never altered or dropped.
- Inputs are not stored. A producer must hold in_data/in_valid until its in_ready=1.
- Reset mid-operation: a pending output word is discarded, out_valid drops immediately, and ptr returns to 0.

Test Plan:
- Reset, then all 8 channels valid with in_data[i]=16'h1000+i, out_ready=1, mode=0 → out_chan sequence 0,1,...,7,0 on consecutive cycles. out_data matches each channel. No idle cycles.
- Mode 0, only channels 2 and 5 valid, out_ready=1 → grants alternate 2,5,2,5. ptr after each grant is 3, 6, 3, 6.
- Backpressure: channel 3 valid with 16'hBEEF, out_ready=0 for 4 cycles → out_valid=1, out_data=16'hBEEF held, in_ready=0 throughout. Raise out_ready → next word loads the same cycle.
- Mode 1, sel=6, channels 0–7 all valid → only in_ready[6] ever asserts, out_chan=6 every cycle, ptr unchanged. Switch to mode 0 → arbitration resumes from the prior ptr.
- WAYS=5, WIDTH=8 instance, mode 1 with sel=7 → no grant, out_valid falls to 0 after drain. Mode 0, all valid → out_chan sequence 0..4, wrapping to 0.
- Assert reset_n=0 asynchronously mid-stream with out_valid=1 → out_valid, out_data and out_chan go to 0 before the next clock edge. After release, the first grant is channel 0.
